// File: rtl/dss_pkg.sv
// Shared types and helpers for digit_serial_subtractor.
// State encoding and the signed-overflow rule.
package dss_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic sub_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic d_msb
  );
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/digit_serial_subtractor_if.sv
// Operand/result handshake bundle for digit_serial_subtractor.
// slave = subtractor side, master = producer/consumer side.
interface digit_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_borrow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] difference;
  logic             out_borrow;
  logic             zero;
  logic             overflow;

  modport slave (
    input  in_valid, a, b, in_borrow, out_ready,
    output in_ready, out_valid, difference,
    output out_borrow, zero, overflow
  );

  modport master (
    output in_valid, a, b, in_borrow, out_ready,
    input  in_ready, out_valid, difference,
    input  out_borrow, zero, overflow
  );
endinterface

// File: rtl/digit_serial_subtractor_slice.sv
// DIGIT-bit borrow-ripple slice built from fullsubtractor cells.
// Pure combinational; one instance per subtractor.
module fullsubtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

module subtractor_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             borrow_in,
  output logic [DIGIT-1:0] d,
  output logic             borrow_out
);
  logic [DIGIT:0] br;

  assign br[0]      = borrow_in;
  assign borrow_out = br[DIGIT];

  for (genvar i = 0; i < DIGIT; i++) begin : g_fs
    fullsubtractor u_fs (
      .x  (x[i]),
      .y  (y[i]),
      .bi (br[i]),
      .d  (d[i]),
      .bo (br[i+1])
    );
  end
endmodule

// File: rtl/digit_serial_subtractor.sv
// Digit-serial a - b - in_borrow, DIGIT bits per clock.
// Define DSS_SATURATE_EN for unsigned saturation at zero.
module digit_serial_subtractor
  import dss_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic clk,
  input logic rst_n,
  digit_serial_subtractor_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr, diff_q;
  logic             brw, bo_q, zero_q, ovf_q;
  logic [DIGIT-1:0] d_dig;
  logic             slc_bo;
  logic             last, load, rdy, vld;
  logic [WIDTH-1:0] d_full, d_final;

  subtractor_slice #(.DIGIT(DIGIT)) u_slice (
    .x          (a_sr[DIGIT-1:0]),
    .y          (b_sr[DIGIT-1:0]),
    .borrow_in  (brw),
    .d          (d_dig),
    .borrow_out (slc_bo)
  );

  // New digit enters at the top; after NDIG shifts digit 0 sits lowest.
  assign d_full = WIDTH'({d_dig, d_sr} >> DIGIT);
  assign last   = (state == RUN) && (cnt == CW'(NDIG - 1));

`ifdef DSS_SATURATE_EN
  assign d_final = slc_bo ? '0 : d_full;
`else
  assign d_final = d_full;
`endif

  always_comb begin
    state_n = state;
    rdy     = 1'b0;
    vld     = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(NDIG - 1)) state_n = DONE;
      end
      DONE: begin
        vld = 1'b1;
        rdy = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            load    = 1'b1;
            state_n = RUN;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      brw    <= 1'b0;
      diff_q <= '0;
      bo_q   <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        a_sr <= bus.a;
        b_sr <= bus.b;
        brw  <= bus.in_borrow;
        d_sr <= '0;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sr <= a_sr >> DIGIT;
        b_sr <= b_sr >> DIGIT;
        d_sr <= d_full;
        brw  <= slc_bo;
        cnt  <= cnt + CW'(1);
        if (last) begin
          diff_q <= d_final;
          bo_q   <= slc_bo;
          zero_q <= (d_final == '0);
          // Top digit is in the slice now: its MSBs are the operand MSBs.
          ovf_q  <= sub_ovf(a_sr[DIGIT-1], b_sr[DIGIT-1],
                            d_dig[DIGIT-1]);
        end
      end
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = vld;
  assign bus.difference = diff_q;
  assign bus.out_borrow = bo_q;
  assign bus.zero       = zero_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: doc/digit_serial_subtractor.md
Name: digit_serial_subtractor

Overview:
- Parametrised multi-cycle binary subtractor computing a - b - in_borrow over WIDTH bits.
- Processes DIGIT bits per clock through a DIGIT-bit borrow-ripple slice and carries the borrow between cycles in a register.
- Uses valid/ready handshakes on both the input and output sides.
- Next-generation replacement for the fixed 4-bit combinational borrow-ripple subtractor; trades latency for area at wide WIDTH.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle. 1 <= DIGIT <= WIDTH.
- NDIG, WIDTH/DIGIT, localparam: number of cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- in_borrow  input  1  borrow into the LSB
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- difference  output  WIDTH  a - b - in_borrow, modulo 2^WIDTH
- out_borrow  output  1  final borrow; 1 iff unsigned a < b + in_borrow
- zero  output  1  difference == 0
- overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low. While rst_n is low:
  - state = IDLE
  - all data registers, counter and borrow register cleared
  - in_ready = 1, out_valid = 0, difference = 0, out_borrow = 0, zero = 0, overflow = 0
- Reset asserted mid-operation aborts that operation; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture a, b and in_borrow into shift registers; cnt = 0; go to RUN.
- RUN:
  - in_ready = 0; inputs are ignored.
  - Each cycle, slice digit cnt (lowest unprocessed DIGIT bits) with the borrow register.
  - Shift the result digit into the difference register from the top, so the LSB digit lands lowest after NDIG shifts.
  - Update the borrow register; cnt++.
  - When cnt == NDIG-1: go to DONE.
- DONE:
  - out_valid = 1.
  - difference, out_borrow, zero and overflow are registered and held stable until the handshake.
  - in_ready = out_ready, so back-to-back operations are possible.
  - out_ready & in_valid: capture the new operands and go to RUN (no bubble).
  - out_ready & !in_valid: go to IDLE.
  - !out_ready: stay in DONE.
- Latency: out_valid rises NDIG cycles after the accepting edge.
- Throughput: one result per NDIG+1 cycles when back-to-back.
- NDIG == 1: RUN lasts exactly one cycle.
- Flags are computed on the final RUN cycle:
  - overflow = (a[W-1] != b[W-1]) & (difference[W-1] != a[W-1]), using the captured a and b.
  - zero reflects the delivered difference.
- in_borrow enters only at digit 0. Intermediate borrows never leave the block.
- Outputs outside DONE keep their last values but are qualified by out_valid = 0.

Optional Feature:
- Macro: DSS_SATURATE_EN.
- Defined: unsigned saturation. When the final borrow is 1, difference is forced to 0 and zero = 1. out_borrow still reports 1. overflow is unaffected (computed from the unsaturated value).
- Undefined: wrap-around modulo 2^WIDTH, as specified above.

Decomposition:
- Shared package dss_pkg holds:
  - state typedef (IDLE/RUN/DONE encoding)
  - signed-overflow helper function
- Parameters remain per-instance.
- Sub-module subtractor_slice: DIGIT-bit combinational borrow-ripple chain.
  - Ports: x[DIGIT], y[DIGIT], borrow_in, d[DIGIT], borrow_out.
  - Built from the existing fullsubtractor cells.
  - Instantiated once in the top.

Test Plan (WIDTH=16, DIGIT=4):
- a=0x1234, b=0x0234, in_borrow=0 -> difference=0x1000, out_borrow=0, zero=0, overflow=0; out_valid exactly 4 cycles after accept.
- a=0x0000, b=0x0001 -> difference=0xFFFF, out_borrow=1, overflow=0.
  - With DSS_SATURATE_EN: difference=0x0000, zero=1, out_borrow=1.
- a=0x8000, b=0x0001 -> difference=0x7FFF, overflow=1, out_borrow=0.
- Borrow-in:
  - a=0x0005, b=0x0004, in_borrow=1 -> difference=0x0000, zero=1.
  - a=0x0005, b=0x0005, in_borrow=1 -> difference=0xFFFF, out_borrow=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Then assert out_ready with in_valid (a=0x00FF, b=0x000F) in the same cycle -> second operation accepted that edge, result 0x00F0 appears 4 cycles later.
- Drop rst_n for 1 cycle on the 2nd RUN cycle -> out_valid=0, in_ready=1, all outputs 0. After release, a=0x0010, b=0x0001 -> difference=0x000F.
